spi_master_engine: RTL and testbench



---
 rtl/spi_pkg.sv | 22 ++
 rtl/sclk_edge_detect.sv | 36 +++
 rtl/spi_master_engine.sv | 190 +++++++++++++++++++
 tb/tb_spi_master_engine.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI master engine.
//   spi_state_t : FSM state encoding (IDLE=0 .. DONE=4), also exported on tp[7:5].
//   TP_*        : bit positions of the fields in the 8-bit debug bus tp.
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ALIGN = 3'd1,
      ST_SHIFT = 3'd2,
      ST_LAST  = 3'd3,
      ST_DONE  = 3'd4
   } spi_state_t;

   localparam int TP_STATE_MSB = 7;
   localparam int TP_STATE_LSB = 5;
   localparam int TP_SS_N      = 4;
   localparam int TP_SCLK      = 3;
   localparam int TP_MOSI      = 2;
   localparam int TP_MISO      = 1;
   localparam int TP_RX_VALID  = 0;

endpackage

// File: rtl/sclk_edge_detect.sv
// Brings the asynchronous bit-rate square wave into the clk domain and
// produces single-cycle edge pulses.
//   clk, reset_n : system clock, asynchronous active-low reset
//   sclk         : asynchronous bit-rate square wave
//   sync         : synchronized level of sclk
//   rise / fall  : one-clk pulses on 0->1 / 1->0 of the synchronized level
module sclk_edge_detect (
   input  logic clk,
   input  logic reset_n,
   input  logic sclk,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta   <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta   <= sclk;
         sync_q <= meta;
         prev_q <= sync_q;
      end
   end

   assign sync = sync_q;
   assign rise = sync_q & ~prev_q;
   assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_master_engine.sv
// Single-slave SPI master, modes 0-3, one DWIDTH-bit word per tx_valid rising edge.
// Bit timing is taken from the external square wave sclk (<= clk/8).
// Build option: define SPI_MASTER_LSB_FIRST_EN to shift LSB first (default MSB first).
//   clk, reset_n          : system clock, asynchronous active-low reset
//   sclk                  : bit-rate square wave (asynchronous)
//   spi_sclk/ss_n/mosi    : SPI outputs (registered);  spi_miso : SPI input
//   tx_valid/tx_ready/tx_data : start request, idle flag, word to send
//   rx_valid/rx_data      : one-clk strobe and last received word
//   tp                    : {state, ss_n, sclk, mosi, miso, rx_valid}
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for a tx_valid rising edge, tx_ready high
// ALIGN    | ss_n asserted, waiting for a falling bit-clock edge (setup)
// SHIFT    | spi_sclk follows sclk, bits move on leading/trailing edges
// LAST     | clock parked at CPOL, ss_n held for half a bit
// DONE     | publish rx_data with a one-clk rx_valid
module spi_master_engine
   import spi_pkg::*;
#(
   parameter int DWIDTH = 16,
   parameter bit CPOL   = 1'b0,
   parameter bit CPHA   = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sclk,
   output logic              spi_sclk,
   output logic              spi_ss_n,
   input  logic              spi_miso,
   output logic              spi_mosi,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [DWIDTH-1:0] tx_data,
   output logic              rx_valid,
   output logic [DWIDTH-1:0] rx_data,
   output logic [7:0]        tp
);

`ifdef SPI_MASTER_LSB_FIRST_EN
   localparam bit LSB_FIRST = 1'b1;
`else
   localparam bit LSB_FIRST = 1'b0;
`endif

   localparam int CW = $clog2(DWIDTH + 1);

   spi_state_t        state, state_nxt;
   logic [DWIDTH-1:0] tx_sr, tx_sr_nxt;
   logic [DWIDTH-1:0] rx_sr, rx_sr_nxt;
   logic [DWIDTH-1:0] rx_data_nxt;
   logic [CW-1:0]     bit_cnt, bit_cnt_nxt;
   logic              ss_n_nxt, sclk_nxt, mosi_nxt, rx_valid_nxt;
   logic              tx_valid_q1, tx_valid_q2, trigger;
   logic              sclk_sync, rise_t, fall_t;

   sclk_edge_detect u_sclk_edge (
      .clk     (clk),
      .reset_n (reset_n),
      .sclk    (sclk),
      .sync    (sclk_sync),
      .rise    (rise_t),
      .fall    (fall_t)
   );

   function automatic logic first_bit(input logic [DWIDTH-1:0] w);
      return LSB_FIRST ? w[0] : w[DWIDTH-1];
   endfunction

   function automatic logic [DWIDTH-1:0] tx_shift(input logic [DWIDTH-1:0] w);
      return LSB_FIRST ? (w >> 1) : (w << 1);
   endfunction

   function automatic logic [DWIDTH-1:0] rx_shift(input logic [DWIDTH-1:0] w, input logic b);
      return LSB_FIRST ? {b, w[DWIDTH-1:1]} : {w[DWIDTH-2:0], b};
   endfunction

   assign trigger  = tx_valid_q1 & ~tx_valid_q2;
   assign tx_ready = (state == ST_IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         tx_sr       <= '0;
         rx_sr       <= '0;
         bit_cnt     <= '0;
         spi_ss_n    <= 1'b1;
         spi_sclk    <= CPOL;
         spi_mosi    <= 1'b0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         tx_valid_q1 <= 1'b0;
         tx_valid_q2 <= 1'b0;
      end else begin
         state       <= state_nxt;
         tx_sr       <= tx_sr_nxt;
         rx_sr       <= rx_sr_nxt;
         bit_cnt     <= bit_cnt_nxt;
         spi_ss_n    <= ss_n_nxt;
         spi_sclk    <= sclk_nxt;
         spi_mosi    <= mosi_nxt;
         rx_data     <= rx_data_nxt;
         rx_valid    <= rx_valid_nxt;
         tx_valid_q1 <= tx_valid;
         tx_valid_q2 <= tx_valid_q1;
      end
   end

   always_comb begin
      state_nxt    = state;
      tx_sr_nxt    = tx_sr;
      rx_sr_nxt    = rx_sr;
      bit_cnt_nxt  = bit_cnt;
      ss_n_nxt     = spi_ss_n;
      sclk_nxt     = CPOL;
      mosi_nxt     = spi_mosi;
      rx_data_nxt  = rx_data;
      rx_valid_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (trigger) begin
               tx_sr_nxt   = tx_data;
               rx_sr_nxt   = '0;
               bit_cnt_nxt = '0;
               ss_n_nxt    = 1'b0;
               state_nxt   = ST_ALIGN;
               // Mode with sampling on the leading edge needs the first bit
               // on the wire before the clock starts.
               if (!CPHA) begin
                  mosi_nxt  = first_bit(tx_data);
                  tx_sr_nxt = tx_shift(tx_data);
               end
            end
         end
         ST_ALIGN: begin
            if (fall_t) state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            sclk_nxt = CPOL ^ sclk_sync;
            if (rise_t) begin
               if (!CPHA) begin
                  rx_sr_nxt   = rx_shift(rx_sr, spi_miso);
                  bit_cnt_nxt = bit_cnt + CW'(1);
               end else begin
                  mosi_nxt  = first_bit(tx_sr);
                  tx_sr_nxt = tx_shift(tx_sr);
               end
            end
            if (fall_t) begin
               if (!CPHA) begin
                  // The final trailing edge ends the word; mosi keeps the last bit.
                  if (bit_cnt == CW'(DWIDTH)) begin
                     state_nxt = ST_LAST;
                  end else begin
                     mosi_nxt  = first_bit(tx_sr);
                     tx_sr_nxt = tx_shift(tx_sr);
                  end
               end else begin
                  rx_sr_nxt   = rx_shift(rx_sr, spi_miso);
                  bit_cnt_nxt = bit_cnt + CW'(1);
                  if (bit_cnt == CW'(DWIDTH - 1)) state_nxt = ST_LAST;
               end
            end
         end
         ST_LAST: begin
            if (rise_t) begin
               ss_n_nxt  = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            rx_data_nxt  = rx_sr;
            rx_valid_nxt = 1'b1;
            state_nxt    = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      tp                            = '0;
      tp[TP_STATE_MSB:TP_STATE_LSB] = state;
      tp[TP_SS_N]                   = spi_ss_n;
      tp[TP_SCLK]                   = spi_sclk;
      tp[TP_MOSI]                   = spi_mosi;
      tp[TP_MISO]                   = spi_miso;
      tp[TP_RX_VALID]               = rx_valid;
   end

endmodule

// File: tb/tb_spi_master_engine.sv
// Bench for spi_master_engine: all four SPI modes instantiated side by side,
// sharing clk, sclk and the request interface. A monitor decodes the SPI
// wire activity of each instance into bit streams and pulse counts.
module tb_spi_master_engine;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sclk = 1'b0;
   logic        tx_valid = 1'b0;
   logic [15:0] tx_data = '0;
   int          miso_mode = 0;   // 0 loopback, 1 tied high, 2 tied low

   wire  [3:0]  ss_n_v, sclk_v, mosi_v, ready_v, rxv_v;
   logic [3:0]  miso_v;
   wire  [15:0] rx_data_a [4];
   wire  [7:0]  tp_a [4];

   always #5 clk = ~clk;
   always #81 sclk = ~sclk;

   always_comb begin
      case (miso_mode)
         1:       miso_v = 4'hF;
         2:       miso_v = 4'h0;
         default: miso_v = mosi_v;
      endcase
   end

   for (genvar g = 0; g < 4; g++) begin : g_dut
      spi_master_engine #(
         .DWIDTH (16),
         .CPOL   ((g % 2) == 1),
         .CPHA   (g >= 2)
      ) u_dut (
         .clk      (clk),
         .reset_n  (reset_n),
         .sclk     (sclk),
         .spi_sclk (sclk_v[g]),
         .spi_ss_n (ss_n_v[g]),
         .spi_miso (miso_v[g]),
         .spi_mosi (mosi_v[g]),
         .tx_valid (tx_valid),
         .tx_ready (ready_v[g]),
         .tx_data  (tx_data),
         .rx_valid (rxv_v[g]),
         .rx_data  (rx_data_a[g]),
         .tp       (tp_a[g])
      );
   end

   int          n_checks = 0;
   int          n_fail = 0;

   int          pulses [4]   = '{default: 0};
   int          rxv_cnt [4]  = '{default: 0};
   int          idle_err [4] = '{default: 0};
   int          busy_err [4] = '{default: 0};
   logic [15:0] cap [4]      = '{default: '0};
   logic [3:0]  prev_sclk    = 4'b1010;

   function automatic logic cpol_of(input int i);
      return (i % 2) == 1;
   endfunction

   function automatic logic cpha_of(input int i);
      return i >= 2;
   endfunction

   // What a slave sees on mosi, in arrival order, packed first-bit-at-MSB.
   function automatic logic [15:0] mosi_model(input logic [15:0] d);
      logic [15:0] w;
      w = '0;
      for (int k = 0; k < 16; k++) begin
`ifdef SPI_MASTER_LSB_FIRST_EN
         w = {w[14:0], d[k]};
`else
         w = {w[14:0], d[15-k]};
`endif
      end
      return w;
   endfunction

   // Slave-side view: leading edge = spi_sclk leaving CPOL; slave samples on
   // leading edge for CPHA=0, trailing edge for CPHA=1.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         logic cp, ch, lead;
         cp = cpol_of(i);
         ch = cpha_of(i);
         if (sclk_v[i] !== prev_sclk[i]) begin
            lead = (sclk_v[i] != cp);
            if (lead) pulses[i]++;
            if (lead != ch) cap[i] = {cap[i][14:0], mosi_v[i]};
         end
         prev_sclk[i] = sclk_v[i];
         if (rxv_v[i] === 1'b1) rxv_cnt[i]++;
         if (ss_n_v[i] === 1'b1 && sclk_v[i] !== cp) idle_err[i]++;
         if (ss_n_v[i] === 1'b0 && ready_v[i] === 1'b1) busy_err[i]++;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic do_xfer(input logic [15:0] d, input logic [15:0] exp_rx, input bit retrig);
      int  p0 [4], r0 [4], ie0 [4], be0 [4];
      bit  done;
      int  cyc;
      for (int i = 0; i < 4; i++) begin
         p0[i] = pulses[i]; r0[i] = rxv_cnt[i]; ie0[i] = idle_err[i]; be0[i] = busy_err[i];
      end
      @(negedge clk);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      chk("ss_n_after_1clk", 64'(ss_n_v), 64'hF);
      @(negedge clk);
      chk("ss_n_after_2clk", 64'(ss_n_v), 64'h0);
      chk("tx_ready_busy", 64'(ready_v), 64'h0);
      if (retrig) begin
         repeat (100) @(negedge clk);
         tx_valid = 1'b0;
         tx_data  = ~d;
         repeat (3) @(negedge clk);
         tx_valid = 1'b1;
      end
      done = 1'b0;
      cyc  = 0;
      while (!done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         done = 1'b1;
         for (int i = 0; i < 4; i++) if (rxv_cnt[i] == r0[i]) done = 1'b0;
      end
      chk("xfer_completed", 64'(done), 64'h1);
      tx_valid = 1'b0;
      if (retrig) repeat (400) @(negedge clk);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rx_data[m%0d]", i), 64'(rx_data_a[i]), 64'(exp_rx));
         chk($sformatf("mosi_bits[m%0d]", i), 64'(cap[i]), 64'(mosi_model(d)));
         chk($sformatf("sclk_pulses[m%0d]", i), 64'(pulses[i] - p0[i]), 64'd16);
         chk($sformatf("rx_valid_cycles[m%0d]", i), 64'(rxv_cnt[i] - r0[i]), 64'd1);
         chk($sformatf("ss_n_idle[m%0d]", i), 64'(ss_n_v[i]), 64'h1);
         chk($sformatf("tx_ready_idle[m%0d]", i), 64'(ready_v[i]), 64'h1);
         chk($sformatf("sclk_idle_level[m%0d]", i), 64'(idle_err[i] - ie0[i]), 64'd0);
         chk($sformatf("ready_while_ss[m%0d]", i), 64'(busy_err[i] - be0[i]), 64'd0);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s_ss_n[m%0d]", tag, i), 64'(ss_n_v[i]), 64'h1);
         chk($sformatf("%s_sclk[m%0d]", tag, i), 64'(sclk_v[i]), 64'(cpol_of(i)));
         chk($sformatf("%s_mosi[m%0d]", tag, i), 64'(mosi_v[i]), 64'h0);
         chk($sformatf("%s_tx_ready[m%0d]", tag, i), 64'(ready_v[i]), 64'h1);
         chk($sformatf("%s_rx_valid[m%0d]", tag, i), 64'(rxv_v[i]), 64'h0);
         chk($sformatf("%s_rx_data[m%0d]", tag, i), 64'(rx_data_a[i]), 64'h0);
         chk($sformatf("%s_tp[m%0d]", tag, i), 64'(tp_a[i]),
             64'({3'b000, 1'b1, cpol_of(i), 1'b0, 1'b0, 1'b0}));
      end
   endtask

   typedef struct {
      logic [15:0] d;
      int          mode;
      logic [15:0] exp_rx;
   } vec_t;

   vec_t vecs [7];

   initial begin
      int   r0 [4];
      bit   reached;
      int   cyc;
      logic [15:0] rd;

      vecs[0] = '{16'hAAAB, 0, 16'hAAAB};
      vecs[1] = '{16'h1234, 0, 16'h1234};
      vecs[2] = '{16'h5A5A, 1, 16'hFFFF};
      vecs[3] = '{16'hC3C3, 2, 16'h0000};
      vecs[4] = '{16'h0000, 0, 16'h0000};
      vecs[5] = '{16'hFFFF, 0, 16'hFFFF};
      vecs[6] = '{16'h8001, 0, 16'h8001};

      reset_n = 1'b0;
      repeat (4) @(negedge clk);
      chk_reset_vals("reset");
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      for (int v = 0; v < 7; v++) begin
         miso_mode = vecs[v].mode;
         do_xfer(vecs[v].d, vecs[v].exp_rx, 1'b0);
         repeat (20) @(negedge clk);
      end
      miso_mode = 0;

      // Second request mid-transfer (with tx_data changed) must be dropped.
      do_xfer(16'h3C96, 16'h3C96, 1'b1);

      // Reset during bit 7 of mode 0.
      for (int i = 0; i < 4; i++) r0[i] = rxv_cnt[i];
      cyc = pulses[0];
      @(negedge clk);
      tx_data  = 16'h5A3C;
      tx_valid = 1'b1;
      reached  = 1'b0;
      for (int k = 0; k < 2000 && !reached; k++) begin
         @(negedge clk);
         if (pulses[0] - cyc >= 7) reached = 1'b1;
      end
      chk("reached_bit7", 64'(reached), 64'h1);
      reset_n  = 1'b0;
      tx_valid = 1'b0;
      #1;
      chk_reset_vals("midreset");
      repeat (5) @(negedge clk);
      reset_n = 1'b1;
      repeat (600) @(negedge clk);
      for (int i = 0; i < 4; i++)
         chk($sformatf("no_rx_valid_after_reset[m%0d]", i), 64'(rxv_cnt[i] - r0[i]), 64'd0);
      do_xfer(16'h5A3C, 16'h5A3C, 1'b0);

      // Random words in loopback: every mode must echo the word.
      for (int n = 0; n < 6; n++) begin
         rd = 16'($urandom);
         do_xfer(rd, rd, 1'b0);
         repeat (5 + $urandom_range(0, 30)) @(negedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
